// File: rtl/fa.sv
// Full adder with a combinational sum/carry path, an optional registered
// capture of that result, and a saturating count of captured carry-outs.
module fa #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             ci,
  input  logic             in_vld,
  output logic             s,
  output logic             co,
  output logic             s_q,
  output logic             co_q,
  output logic             out_vld,
  output logic [CNT_W-1:0] co_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s_d;
  logic             co_d;
  logic             out_vld_d;
  logic             out_vld_q;
  logic [CNT_W-1:0] co_cnt_d;
  logic [CNT_W-1:0] co_cnt_q;

  // Pure combinational adder; independent of clk and reset, lets X propagate.
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

  assign out_vld = out_vld_q;
  assign co_cnt  = co_cnt_q;

  // Next-state: capture on in_vld, otherwise hold; counter saturates at max.
  always_comb begin
    s_d       = s_q;
    co_d      = co_q;
    out_vld_d = in_vld;
    co_cnt_d  = co_cnt_q;
    if (in_vld) begin
      s_d  = s;
      co_d = co;
      if (co && (co_cnt_q != CNT_MAX)) begin
        co_cnt_d = co_cnt_q + CNT_ONE;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q       <= 1'b0;
      co_q      <= 1'b0;
      out_vld_q <= 1'b0;
      co_cnt_q  <= '0;
    end else begin
      s_q       <= s_d;
      co_q      <= co_d;
      out_vld_q <= out_vld_d;
      co_cnt_q  <= co_cnt_d;
    end
  end

endmodule

// File: tb/tb_fa.sv
// Directed bench for fa: truth-table walk, reset behaviour, capture path and
// counter saturation, with a scoreboard queue for registered results.
module tb_fa;

  logic       clk;
  logic       reset;
  logic       a;
  logic       b;
  logic       ci;
  logic       in_vld;
  logic       s8;
  logic       co8;
  logic       s_q8;
  logic       co_q8;
  logic       out_vld8;
  logic [7:0] co_cnt8;
  logic       s2;
  logic       co2;
  logic       s_q2;
  logic       co_q2;
  logic       out_vld2;
  logic [1:0] co_cnt2;

  typedef struct packed {
    logic       s;
    logic       co;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];

  int unsigned passes;
  int unsigned total;

  // Expected state of the registered path
  logic       m_s;
  logic       m_co;
  logic [7:0] m_c8;
  logic [1:0] m_c2;

  // Truth table {s,co} indexed by {a,b,ci}
  logic [1:0] tt [8];

  fa dut8 (
    .clk(clk), .reset(reset), .a(a), .b(b), .ci(ci), .in_vld(in_vld),
    .s(s8), .co(co8), .s_q(s_q8), .co_q(co_q8), .out_vld(out_vld8), .co_cnt(co_cnt8)
  );

  fa #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .ci(ci), .in_vld(in_vld),
    .s(s2), .co(co2), .s_q(s_q2), .co_q(co_q2), .out_vld(out_vld2), .co_cnt(co_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_s  = 1'b0;
    m_co = 1'b0;
    m_c8 = 8'd0;
    m_c2 = 2'd0;
  endtask

  task automatic check_regs(input string tag, input logic es, input logic eco,
                            input logic ev, input logic [7:0] e8, input logic [1:0] e2);
    check({tag, ".s_q"},     32'(s_q8),     32'(es));
    check({tag, ".co_q"},    32'(co_q8),    32'(eco));
    check({tag, ".out_vld"}, 32'(out_vld8), 32'(ev));
    check({tag, ".cnt8"},    32'(co_cnt8),  32'(e8));
    check({tag, ".s_q2"},    32'(s_q2),     32'(es));
    check({tag, ".co_q2"},   32'(co_q2),    32'(eco));
    check({tag, ".vld2"},    32'(out_vld2), 32'(ev));
    check({tag, ".cnt2"},    32'(co_cnt2),  32'(e2));
  endtask

  task automatic check_comb(input string tag, input logic [2:0] v);
    logic [1:0] e;
    e = tt[v];
    check({tag, ".s"},   32'(s8),  32'(e[1]));
    check({tag, ".co"},  32'(co8), 32'(e[0]));
    check({tag, ".s2"},  32'(s2),  32'(e[1]));
    check({tag, ".co2"}, 32'(co2), 32'(e[0]));
  endtask

  // Drive one cycle; captures push an expectation that is popped after the edge.
  task automatic step(input string tag, input logic [2:0] v, input logic vld);
    exp_t       e;
    logic [1:0] r;
    {a, b, ci} = v;
    in_vld     = vld;
    if (vld) begin
      r = tt[v];
      m_s  = r[1];
      m_co = r[0];
      if (r[0]) begin
        if (m_c8 != 8'hff) m_c8 = m_c8 + 8'd1;
        if (m_c2 != 2'h3)  m_c2 = m_c2 + 2'd1;
      end
      sb.push_back('{s: m_s, co: m_co, c8: m_c8, c2: m_c2});
    end
    tick();
    if (vld) begin
      if (sb.size() == 0) begin
        check({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_regs(tag, e.s, e.co, 1'b1, e.c8, e.c2);
      end
    end else begin
      check_regs(tag, m_s, m_co, 1'b0, m_c8, m_c2);
    end
  endtask

  initial begin
    tt[0] = 2'b00; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b11;
    passes = 0;
    total  = 0;
    clk    = 1'b0;
    reset  = 1'b1;
    {a, b, ci} = 3'b000;
    in_vld = 1'b0;
    model_reset();
    #1;
    check_regs("reset_state", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

    // Exhaustive walk during reset, clock idle
    for (int i = 0; i < 8; i++) begin
      {a, b, ci} = 3'(i);
      #10;
      check_comb("tt_rst", 3'(i));
    end

    // Reset holds registers despite clocking with in_vld
    {a, b, ci} = 3'b111;
    in_vld     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_comb("rst_comb", 3'b111);
      check_regs("rst_hold", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    end
    in_vld = 1'b0;
    #2 reset = 1'b0;
    #1;

    // Exhaustive walk out of reset, clock idle
    for (int i = 7; i >= 0; i--) begin
      {a, b, ci} = 3'(i);
      #10;
      check_comb("tt_run", 3'(i));
    end

    // Single capture of 110, then a hold cycle
    step("cap110", 3'b110, 1'b1);
    step("hold110", 3'b001, 1'b0);
    step("cap111", 3'b111, 1'b1);

    // Asynchronous reset between edges while counter is 2
    #2 reset = 1'b1;
    #1;
    check_regs("async_rst", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    {a, b, ci} = 3'b011;
    in_vld = 1'b1;
    tick();
    check_regs("rst_pend", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    in_vld = 1'b0;
    reset  = 1'b0;
    model_reset();
    #1;

    // Saturation: five carry captures
    for (int i = 0; i < 5; i++) step("sat", 3'b111, 1'b1);
    step("sat_hold", 3'b000, 1'b0);
    step("sat_nc", 3'b100, 1'b1);

    // Capture without carry leaves counter at zero
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    #1;
    step("cap100", 3'b100, 1'b1);

    // Mixed pseudo-random traffic
    for (int i = 0; i < 40; i++) begin
      step("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/fa.md
FA -- requirements
Module: fa

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, the width of the carry-event counter (legal range 1..32).
REQ-002 The module SHALL have port clk, input, 1 bit; the single clock, with all state updating on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-004 The module SHALL have port a, input, 1 bit; addend bit A.
REQ-005 The module SHALL have port b, input, 1 bit; addend bit B.
REQ-006 The module SHALL have port ci, input, 1 bit; carry-in.
REQ-007 The module SHALL have port in_vld, input, 1 bit; capture strobe for the registered path.
REQ-008 The module SHALL have port s, output, 1 bit; combinational sum.
REQ-009 The module SHALL have port co, output, 1 bit; combinational carry-out.
REQ-010 The module SHALL have port s_q, output, 1 bit; registered sum.
REQ-011 The module SHALL have port co_q, output, 1 bit; registered carry-out.
REQ-012 The module SHALL have port out_vld, output, 1 bit; registered-result valid flag.
REQ-013 The module SHALL have port co_cnt, output, CNT_W bits; saturating count of captured carry-outs.

Function
REQ-014 s SHALL equal a XOR b XOR ci, purely combinational, with no dependence on clk or reset.
REQ-015 co SHALL equal (a AND b) OR (a AND ci) OR (b AND ci), purely combinational, with no dependence on clk or reset.
REQ-016 Truth table (a,b,ci -> s,co) SHALL be: 000->00, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11.
REQ-017 s and co SHALL be valid at all times, including during reset, and SHALL settle within one propagation delay of any input change.
REQ-018 On a rising clk edge with in_vld=1, s_q and co_q SHALL load the current s and co, and out_vld SHALL be 1 on the following cycle (latency 1 cycle).
REQ-019 On a rising clk edge with in_vld=0, s_q and co_q SHALL hold their values and out_vld SHALL go to 0.
REQ-020 On a rising clk edge with in_vld=1 and co=1, co_cnt SHALL increment by 1.
REQ-021 co_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 While the counter is saturated, further carry captures SHALL leave co_cnt unchanged.
REQ-023 X or Z on a, b, ci SHALL not be resolved internally; propagation of X is acceptable.

Reset
REQ-024 Asserting reset SHALL immediately (asynchronously) force s_q=0, co_q=0, out_vld=0 and co_cnt=0.
REQ-025 Registered outputs SHALL remain at their reset values while reset is high, regardless of clk and in_vld.
REQ-026 On the first rising clk edge after reset deasserts, normal capture SHALL resume.
REQ-027 Reset asserted mid-operation SHALL discard any pending capture.
REQ-028 Reset SHALL have no effect on the combinational outputs s and co.

Verification
REQ-029 Exhaustive walk of a,b,ci over 000..111, 10 ns per step, clk idle -> s/co match the truth table at every step (e.g. 011 gives s=0, co=1; 111 gives s=1, co=1).
REQ-030 reset=1, then a=b=ci=1 with in_vld=1 and clk toggling -> s=1, co=1 while s_q, co_q, out_vld and co_cnt stay 0.
REQ-031 After reset, in_vld=1 with a,b,ci=110 for one edge -> next cycle s_q=0, co_q=1, out_vld=1, co_cnt=1; then in_vld=0 for one edge -> out_vld=0 and s_q/co_q held.
REQ-032 With CNT_W=2, apply 5 captures with co=1 -> co_cnt sequence 1,2,3,3,3.
REQ-033 Assert reset between clock edges while co_cnt=2 -> co_cnt=0 and out_vld=0 immediately, without waiting for a clock edge.
REQ-034 After reset, capture a,b,ci=100 -> s_q=1, co_q=0, co_cnt unchanged at 0.
